// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: FIFO-buffered 8N1 UART transmitter with per-frame done pulse and sticky overflow flag
module uart_tx_buffered #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int FIFO_DEPTH   = 4,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_write,
    input  logic [7:0] tx_bus,
    output logic       tx,
    output logic       tx_done,
    output logic       tx_full,
    output logic       tx_empty,
    output logic       tx_busy,
    output logic       tx_overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(STOP_BITS * CLKS_PER_BIT);
    localparam logic [TW-1:0] BIT_T  = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] STOP_T = TW'(STOP_BITS * CLKS_PER_BIT - 1);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    state_t        state_q;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wp_q, rp_q;
    logic [CW-1:0] count_q, count_d;
    logic [TW-1:0] timer_q;
    logic [2:0]    idx_q;
    logic [7:0]    shift_q;
    logic          tx_q, done_q, full_q, empty_q, ovf_q, pop, wr;
    always_comb begin
        pop     = count_q != '0 && (state_q == IDLE || (state_q == STOP && timer_q == '0));
        wr      = tx_write && (count_q < CW'(FIFO_DEPTH) || pop);
        count_d = count_q + CW'(wr) - CW'(pop);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
            timer_q <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            count_q <= count_d;
            full_q  <= count_d == CW'(FIFO_DEPTH);
            empty_q <= count_d == '0;
            ovf_q   <= ovf_q | (tx_write & ~wr);
            if (wr) begin
                mem_q[wp_q] <= tx_bus;
                wp_q        <= wp_q + AW'(1);
            end
            if (pop) rp_q <= rp_q + AW'(1);
            case (state_q)
                IDLE: if (pop) begin
                    shift_q <= mem_q[rp_q];
                    timer_q <= BIT_T;
                    tx_q    <= 1'b0;
                    state_q <= START;
                end
                START: if (timer_q == '0) begin
                    timer_q <= BIT_T;
                    idx_q   <= '0;
                    tx_q    <= shift_q[0];
                    state_q <= DATA;
                end else timer_q <= timer_q - TW'(1);
                DATA: if (timer_q == '0) begin
                    if (idx_q == 3'd7) begin
                        timer_q <= STOP_T;
                        tx_q    <= 1'b1;
                        state_q <= STOP;
                    end else begin
                        timer_q <= BIT_T;
                        idx_q   <= idx_q + 3'd1;
                        shift_q <= shift_q >> 1;
                        tx_q    <= shift_q[1];
                    end
                end else timer_q <= timer_q - TW'(1);
                STOP: if (timer_q == '0) begin
                    done_q <= 1'b1;
                    if (pop) begin
                        shift_q <= mem_q[rp_q];
                        timer_q <= BIT_T;
                        tx_q    <= 1'b0;
                        state_q <= START;
                    end else state_q <= IDLE;
                end else timer_q <= timer_q - TW'(1);
                default: state_q <= IDLE;
            endcase
        end
    end
    assign tx          = tx_q;
    assign tx_done     = done_q;
    assign tx_full     = full_q;
    assign tx_empty    = empty_q;
    assign tx_busy     = state_q != IDLE;
    assign tx_overflow = ovf_q;
endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb_uart_tx_buffered: table vectors plus serial-decoding scoreboard for uart_tx_buffered
module tb_uart_tx_buffered;
    logic clk = 1'b0;
    logic rst1 = 1'b1, wr1 = 1'b0, rst2 = 1'b1, wr2 = 1'b0;
    logic [7:0] bus1 = '0, bus2 = '0;
    logic tx1, done1, full1, empty1, busy1, ovf1;
    logic tx2, done2, full2, empty2, busy2, ovf2;
    int checks = 0, errors = 0;
    logic [7:0] sb [$];
    int done_cnt = 0, mcnt = 0;
    logic active = 1'b0, full_seen = 1'b0;
    logic [7:0] shreg = '0;
    typedef struct {
        logic       wr;
        logic [7:0] bus;
        logic       tx, done, busy, empty;
    } vec_t;
    vec_t tv [50];

    always #5 clk = ~clk;

    uart_tx_buffered #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4), .STOP_BITS(1)) d1 (
        .clk(clk), .reset(rst1), .tx_write(wr1), .tx_bus(bus1), .tx(tx1), .tx_done(done1),
        .tx_full(full1), .tx_empty(empty1), .tx_busy(busy1), .tx_overflow(ovf1));
    uart_tx_buffered #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4), .STOP_BITS(2)) d2 (
        .clk(clk), .reset(rst2), .tx_write(wr2), .tx_bus(bus2), .tx(tx2), .tx_done(done2),
        .tx_full(full2), .tx_empty(empty2), .tx_busy(busy2), .tx_overflow(ovf2));

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", n, a, e, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick();
        rst1 = 1'b1; rst2 = 1'b1; wr1 = 1'b0; wr2 = 1'b0;
        tick();
        tick();
        rst1 = 1'b0; rst2 = 1'b0;
        sb.delete();
    endtask

    task automatic fill(input logic [7:0] b, input int stops);
        logic [11:0] f;
        int len;
        f = '1;
        f[0] = 1'b0;
        f[8:1] = b;
        len = 4 * (9 + stops);
        for (int c = 0; c < 50; c++) begin
            tv[c].wr    = (c == 0);
            tv[c].bus   = b;
            tv[c].tx    = (c >= 2 && c < 2 + len) ? f[(c - 2) / 4] : 1'b1;
            tv[c].done  = (c == 2 + len);
            tv[c].busy  = (c >= 2 && c < 2 + len);
            tv[c].empty = (c != 1);
        end
    endtask

    task automatic run_table(input logic s, input string tag);
        for (int c = 0; c < 50; c++) begin
            if (s) begin wr2 = tv[c].wr; bus2 = tv[c].bus; end
            else begin wr1 = tv[c].wr; bus1 = tv[c].bus; end
            @(negedge clk);
            chk($sformatf("%s_tx[%0d]", tag, c), s ? tx2 : tx1, tv[c].tx);
            chk($sformatf("%s_done[%0d]", tag, c), s ? done2 : done1, tv[c].done);
            chk($sformatf("%s_busy[%0d]", tag, c), s ? busy2 : busy1, tv[c].busy);
            chk($sformatf("%s_empty[%0d]", tag, c), s ? empty2 : empty1, tv[c].empty);
            tick();
        end
        wr1 = 1'b0; wr2 = 1'b0;
    endtask

    initial forever begin
        @(negedge clk);
        if (rst1) active = 1'b0;
        else begin
            if (done1) done_cnt++;
            if (full1) full_seen = 1'b1;
            if (!active && !tx1) begin active = 1'b1; mcnt = 0; end
            if (active) begin
                if (mcnt == 2) chk("start_bit", tx1, 0);
                if (mcnt >= 6 && mcnt <= 34 && mcnt % 4 == 2) shreg = {tx1, shreg[7:1]};
                if (mcnt == 38) begin
                    chk("stop_bit", tx1, 1);
                    if (sb.size() == 0) chk("sb_unexpected_byte", shreg, 32'hFFFF_FFFF);
                    else chk("sb_byte", shreg, sb.pop_front());
                end
                if (mcnt == 39) active = 1'b0;
                else mcnt++;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    initial begin
        int pre, bad;
        logic got;
        logic [7:0] pb [3];
        pb = '{8'h12, 8'h34, 8'h56};
        do_reset();
        @(negedge clk);
        chk("rst_tx", tx1, 1);
        chk("rst_done", done1, 0);
        chk("rst_full", full1, 0);
        chk("rst_empty", empty1, 1);
        chk("rst_busy", busy1, 0);
        chk("rst_ovf", ovf1, 0);
        tick();
        // single byte, cycle-exact
        fill(8'h41, 1);
        sb.push_back(8'h41);
        run_table(1'b0, "t1");
        chk("t1_sb", sb.size(), 0);
        // paced producer
        do_reset();
        pre = done_cnt;
        full_seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wr1 = 1'b1; bus1 = pb[i]; sb.push_back(pb[i]);
            tick();
            wr1 = 1'b0;
            got = 1'b0;
            for (int c = 0; c < 80 && !got; c++) begin
                @(negedge clk);
                if (done1) got = 1'b1;
                tick();
            end
            chk($sformatf("t2_done%0d", i), got, 1);
        end
        tick();
        chk("t2_pulses", done_cnt - pre, 3);
        chk("t2_full_seen", full_seen, 0);
        chk("t2_sb", sb.size(), 0);
        // burst with overflow
        do_reset();
        pre = done_cnt;
        for (int c = 0; c < 210; c++) begin
            wr1 = (c < 6);
            bus1 = 8'(c + 1);
            if (c < 5) sb.push_back(8'(c + 1));
            @(negedge clk);
            chk($sformatf("t3_busy[%0d]", c), busy1, (c >= 2 && c <= 201));
            chk($sformatf("t3_done[%0d]", c), done1, (c >= 42 && c <= 202 && (c - 42) % 40 == 0));
            if (c == 4 || c == 5) chk($sformatf("t3_full[%0d]", c), full1, (c == 5));
            if (c == 5 || c == 6 || c == 209) chk($sformatf("t3_ovf[%0d]", c), ovf1, (c >= 6));
            tick();
        end
        wr1 = 1'b0;
        chk("t3_pulses", done_cnt - pre, 5);
        chk("t3_sb", sb.size(), 0);
        // write while full, coinciding with the STOP->START pop
        do_reset();
        pre = done_cnt;
        for (int c = 0; c < 250; c++) begin
            wr1 = (c < 5 || c == 41);
            bus1 = (c == 41) ? 8'h66 : 8'(8'h11 * (c + 1));
            if (wr1) sb.push_back(bus1);
            @(negedge clk);
            if (c == 41 || c == 42) chk($sformatf("t4_full[%0d]", c), full1, 1);
            if (c == 42 || c == 249) chk($sformatf("t4_ovf[%0d]", c), ovf1, 0);
            tick();
        end
        wr1 = 1'b0;
        chk("t4_pulses", done_cnt - pre, 6);
        chk("t4_sb", sb.size(), 0);
        // reset mid-frame
        do_reset();
        pre = done_cnt;
        bad = 0;
        for (int c = 0; c < 100; c++) begin
            wr1 = (c < 2);
            bus1 = (c == 0) ? 8'hA5 : 8'h3C;
            rst1 = (c == 15);
            if (c == 15) sb.delete();
            @(negedge clk);
            if (c == 16) begin
                chk("t5_tx", tx1, 1);
                chk("t5_busy", busy1, 0);
                chk("t5_empty", empty1, 1);
            end
            if (c >= 16 && (tx1 !== 1'b1 || done1 !== 1'b0)) bad++;
            tick();
        end
        wr1 = 1'b0;
        chk("t5_quiet", bad, 0);
        chk("t5_no_done", done_cnt - pre, 0);
        wr1 = 1'b1; bus1 = 8'h7E; sb.push_back(8'h7E);
        tick();
        wr1 = 1'b0;
        repeat (60) tick();
        chk("t5_after_pulses", done_cnt - pre, 1);
        chk("t5_sb", sb.size(), 0);
        // two stop bits
        do_reset();
        fill(8'hFF, 2);
        run_table(1'b1, "t6");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
